// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared constants and helpers for the pipelined carry-lookahead adder.
//   CLA_GRP   : number of sum bits produced by one lookahead group / stage
//   cla_nstg  : number of pipeline stages needed for a given operand width
// -----------------------------------------------------------------------------
package cla_pkg;

  localparam int CLA_GRP = 4;

  // One pipeline stage per lookahead group, so the stage count is simply the
  // operand width divided by the group width.
  function automatic int cla_nstg(input int width, input int grp = CLA_GRP);
    return width / grp;
  endfunction

endpackage

// File: rtl/cla_grp.sv
// -----------------------------------------------------------------------------
// cla_grp
// Purely combinational GRP-bit carry-lookahead group.
// Ports:
//   A, B  in  GRP  operand slices (B already inverted by the caller for subtract)
//   Cin   in  1    carry into the least significant bit of the group
//   SUM   out GRP  group sum
//   Cout  out 1    carry out of the group MSB
//   Cmsb  out 1    carry into the group MSB (used for signed overflow)
// -----------------------------------------------------------------------------
module cla_grp
  import cla_pkg::*;
#(
  parameter int GRP = CLA_GRP
) (
  input  logic [GRP-1:0] A,
  input  logic [GRP-1:0] B,
  input  logic           Cin,
  output logic [GRP-1:0] SUM,
  output logic           Cout,
  output logic           Cmsb
);

  logic [GRP-1:0] gen;
  logic [GRP-1:0] prop;
  logic [GRP:0]   carry;

  assign gen  = A & B;
  assign prop = A ^ B;

  // Every carry is formed directly as a sum of products of the group's
  // generate/propagate terms and Cin, so no carry waits on a lower carry:
  //   c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..1]g[0] | p[i..0]Cin
  always_comb begin
    logic term;
    logic cval;
    carry    = '0;
    carry[0] = Cin;
    term     = 1'b0;
    cval     = 1'b0;
    for (int i = 0; i < GRP; i++) begin
      cval = 1'b0;
      for (int j = 0; j < GRP; j++) begin
        if (j <= i) begin
          term = gen[j];
          for (int m = 0; m < GRP; m++) begin
            if (m > j && m <= i) begin
              term = term & prop[m];
            end
          end
          cval = cval | term;
        end
      end
      term = Cin;
      for (int m = 0; m < GRP; m++) begin
        if (m <= i) begin
          term = term & prop[m];
        end
      end
      carry[i+1] = cval | term;
    end
  end

  assign SUM  = prop ^ carry[GRP-1:0];
  assign Cout = carry[GRP];
  assign Cmsb = carry[GRP-1];

endmodule

// File: rtl/pipe_cla_adder.sv
// -----------------------------------------------------------------------------
// pipe_cla_adder
// Valid/ready pipelined adder/subtractor. Each stage resolves one GRP-bit
// lookahead group using the carry registered by the stage before it, so a
// beat takes NSTG = WIDTH/GRP cycles from input transfer to out_valid and the
// pipe accepts one beat per cycle while the output is being drained.
// Ports:
//   clk        in  1      rising-edge clock
//   rst_n      in  1      synchronous active-low reset
//   in_valid   in  1      operand beat offered
//   in_ready   out 1      beat accepted this cycle (low only while stalled)
//   A, B       in  WIDTH  operands
//   Cin        in  1      carry in (ignored when SUB=1)
//   SUB        in  1      0: A+B+Cin, 1: A-B
//   out_valid  out 1      result present
//   out_ready  in  1      downstream accepts result
//   SUM        out WIDTH  result modulo 2^WIDTH
//   Cout       out 1      carry out of MSB (for SUB, 1 = no borrow)
//   OVF        out 1      signed two's-complement overflow
// -----------------------------------------------------------------------------
module pipe_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GRP   = CLA_GRP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] SUM,
  output logic             Cout,
  output logic             OVF
);

  localparam int NSTG = cla_nstg(WIDTH, GRP);

  if ((GRP < 1) || ((WIDTH % GRP) != 0)) begin : gen_width_check
    $error("pipe_cla_adder: WIDTH (%0d) must be a non-zero multiple of GRP (%0d)", WIDTH, GRP);
  end

  if ((WIDTH < 4) || (WIDTH > 64)) begin : gen_range_check
    $error("pipe_cla_adder: WIDTH (%0d) must lie in 4..64", WIDTH);
  end

  // Per-stage inputs: stage 0 is fed from the ports, stage k from the
  // registers of stage k-1. Operands are kept right-aligned, so every stage
  // works on the low GRP bits and passes the remainder shifted down.
  logic [WIDTH-1:0] stgA   [NSTG];
  logic [WIDTH-1:0] stgB   [NSTG];
  logic [WIDTH-1:0] stgSum [NSTG];
  logic [NSTG-1:0]  stgCin;
  logic [NSTG-1:0]  stgVld;

  logic [GRP-1:0]   grpSum [NSTG];
  logic [NSTG-1:0]  grpCout;
  logic [NSTG-1:0]  grpCmsb;

  // Pipeline registers. Finished sum bits enter at the top and shift right,
  // so after the last stage group 0 sits at bit 0.
  logic [WIDTH-1:0] opA_q  [NSTG];
  logic [WIDTH-1:0] opB_q  [NSTG];
  logic [WIDTH-1:0] sum_q  [NSTG];
  logic [NSTG-1:0]  cry_q;
  logic [NSTG-1:0]  vld_q;
  logic             ovf_q;

  logic             stall;

  // A held result freezes the whole pipe; nothing else can block it, which
  // keeps in_ready free of any path from in_valid.
  assign stall    = vld_q[NSTG-1] & ~out_ready;
  assign in_ready = ~stall;

  for (genvar k = 0; k < NSTG; k++) begin : gen_stage
    if (k == 0) begin : gen_first
      // Subtraction is A + ~B + 1: invert B as it enters and force carry-in.
      assign stgA[k]   = A;
      assign stgB[k]   = SUB ? ~B : B;
      assign stgCin[k] = SUB | Cin;
      assign stgSum[k] = '0;
      assign stgVld[k] = in_valid;
    end else begin : gen_next
      assign stgA[k]   = opA_q[k-1];
      assign stgB[k]   = opB_q[k-1];
      assign stgCin[k] = cry_q[k-1];
      assign stgSum[k] = sum_q[k-1];
      assign stgVld[k] = vld_q[k-1];
    end

    cla_grp #(
      .GRP (GRP)
    ) u_grp (
      .A    (stgA[k][GRP-1:0]),
      .B    (stgB[k][GRP-1:0]),
      .Cin  (stgCin[k]),
      .SUM  (grpSum[k]),
      .Cout (grpCout[k]),
      .Cmsb (grpCmsb[k])
    );
  end

  // Whole-pipe advance. Bubbles move along with real beats whenever the
  // output is not stalled. Only valid bits and the output register are
  // reset; the output register only loads real beats so SUM/Cout/OVF keep
  // the last result instead of picking up bubble contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q           <= '0;
      sum_q[NSTG-1]   <= '0;
      cry_q[NSTG-1]   <= 1'b0;
      ovf_q           <= 1'b0;
    end else if (!stall) begin
      vld_q <= stgVld;
      for (int k = 0; k < NSTG - 1; k++) begin
        opA_q[k] <= stgA[k] >> GRP;
        opB_q[k] <= stgB[k] >> GRP;
        sum_q[k] <= WIDTH'({grpSum[k], stgSum[k]} >> GRP);
        cry_q[k] <= grpCout[k];
      end
      if (stgVld[NSTG-1]) begin
        sum_q[NSTG-1] <= WIDTH'({grpSum[NSTG-1], stgSum[NSTG-1]} >> GRP);
        cry_q[NSTG-1] <= grpCout[NSTG-1];
        ovf_q         <= grpCmsb[NSTG-1] ^ grpCout[NSTG-1];
      end
    end
  end

  assign out_valid = vld_q[NSTG-1];
  assign SUM       = sum_q[NSTG-1];
  assign Cout      = cry_q[NSTG-1];
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// -----------------------------------------------------------------------------
// tb_pipe_cla_adder
// Self-checking bench for pipe_cla_adder at WIDTH=16. Accepted beats are
// turned into expected results by plain arithmetic and queued; results are
// matched in order on every output transfer.
// -----------------------------------------------------------------------------
module tb_pipe_cla_adder;

  localparam int WIDTH = 16;
  localparam int NSTG  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             SUB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] SUM;
  logic             Cout;
  logic             OVF;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               due;
  } expect_t;

  expect_t expQ[$];
  int      checkCount = 0;
  int      missCount  = 0;
  int      cycleCount = 0;
  bit      latencyMode;
  bit      prevStall;

  logic [WIDTH-1:0] dirA   [6] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'hFFFF};
  logic [WIDTH-1:0] dirB   [6] = '{16'h0003, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0000};
  logic             dirCin [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic             dirSub [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  pipe_cla_adder #(
    .WIDTH (WIDTH),
    .GRP   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .SUB       (SUB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .SUM       (SUM),
    .Cout      (Cout),
    .OVF       (OVF)
  );

  // Arithmetic reference: full-precision add or subtract, then wrap.
  function automatic expect_t refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic cin, input logic sub);
    expect_t     e;
    logic [WIDTH:0] full;
    if (sub) begin
      full   = 17'(a) - 17'(b);
      e.sum  = full[WIDTH-1:0];
      e.cout = (a >= b);
      e.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
    end else begin
      full   = 17'(a) + 17'(b) + 17'(cin);
      e.sum  = full[WIDTH-1:0];
      e.cout = full[WIDTH];
      e.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
    end
    e.due = 0;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, cycleCount);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin, input logic sub, input logic ordy);
    in_valid  = v;
    A         = a;
    B         = b;
    Cin       = cin;
    SUB       = sub;
    out_ready = ordy;
  endtask

  // One clock: inspect at the falling edge, book transfers, then step past
  // the rising edge.
  task automatic stepCycle(output bit took);
    expect_t e;
    took = 1'b0;
    @(negedge clk);
    if (!rst_n) begin
      if (out_ready) checkOutput("rst_in_ready", 32'(in_ready), 32'(1));
      prevStall = 1'b0;
    end else begin
      if (out_ready) checkOutput("in_ready_open", 32'(in_ready), 32'(1));
      if (prevStall) begin
        checkOutput("stall_valid", 32'(out_valid), 32'(1));
        if (expQ.size() > 0) begin
          checkOutput("stall_sum", 32'(SUM), 32'(expQ[0].sum));
          checkOutput("stall_cout", 32'(Cout), 32'(expQ[0].cout));
          checkOutput("stall_ovf", 32'(OVF), 32'(expQ[0].ovf));
        end
        if (!out_ready) checkOutput("stall_in_ready", 32'(in_ready), 32'(0));
      end
      if (expQ.size() == 0) begin
        checkOutput("idle_valid", 32'(out_valid), 32'(0));
      end else if (latencyMode && expQ[0].due <= cycleCount) begin
        checkOutput("due_valid", 32'(out_valid), 32'(1));
      end
      if (out_valid && out_ready && expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("sum", 32'(SUM), 32'(e.sum));
        checkOutput("cout", 32'(Cout), 32'(e.cout));
        checkOutput("ovf", 32'(OVF), 32'(e.ovf));
        if (latencyMode) checkOutput("latency", 32'(cycleCount), 32'(e.due));
      end
      if (in_valid && in_ready) begin
        e     = refModel(A, B, Cin, SUB);
        e.due = cycleCount + NSTG;
        expQ.push_back(e);
        took  = 1'b1;
      end
      prevStall = out_valid && !out_ready;
    end
    @(posedge clk);
    #1;
    cycleCount++;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'(0));
    checkOutput({tag, "_sum"}, 32'(SUM), 32'(0));
    checkOutput({tag, "_cout"}, 32'(Cout), 32'(0));
    checkOutput({tag, "_ovf"}, 32'(OVF), 32'(0));
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'(1));
  endtask

  task automatic drain(input int budget);
    bit took;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < budget && expQ.size() > 0; i++) stepCycle(took);
    checkOutput("drain_empty", 32'(expQ.size()), 32'(0));
    expQ.delete();
    stepCycle(took);
    stepCycle(took);
  endtask

  initial begin
    bit took;
    int idx;
    int accepted;

    // Power-up reset.
    latencyMode = 1'b1;
    prevStall   = 1'b0;
    rst_n       = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    stepCycle(took);
    stepCycle(took);
    rst_n = 1'b1;
    checkReset("init_rst");

    // Directed corner beats, back to back, exact latency checked.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, dirA[i], dirB[i], dirCin[i], dirSub[i], 1'b1);
      stepCycle(took);
    end
    drain(20);

    // Eight-beat stream with a three-cycle output stall in the middle.
    latencyMode = 1'b0;
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      applyStimulus(idx < 8, 16'(idx * 4099 + 17), 16'(idx * 257 + 3), idx[0], (idx == 5),
                    !(c >= 5 && c <= 7));
      stepCycle(took);
      if (took) idx++;
    end
    checkOutput("stream_accepted", 32'(idx), 32'(8));
    drain(30);

    // Reset with three beats in flight, then a fresh beat.
    latencyMode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 16'(16'h1111 * (i + 1)), 16'h0101, 1'b1, 1'b0, 1'b1);
      stepCycle(took);
    end
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    stepCycle(took);
    expQ.delete();
    rst_n = 1'b1;
    checkReset("mid_rst");
    for (int i = 0; i < 5; i++) stepCycle(took);
    applyStimulus(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
    stepCycle(took);
    drain(20);

    // Random traffic with random handshakes on both sides.
    latencyMode = 1'b0;
    accepted = 0;
    for (int c = 0; c < 40000 && accepted < 10000; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) != 0);
      stepCycle(took);
      if (took) accepted++;
    end
    checkOutput("random_accepted", 32'(accepted), 32'(10000));
    drain(100);

    $display("== %0d vectors applied, %0d miscompares ==", checkCount, missCount);
    $finish;
  end

endmodule
